rw_4x4_arbiter: RTL and testbench

Two-port arbiter and sequencer for a 4-entry x 4-bit read/write store. It shares one synchronous storage array between two requesters using round-robin priority and a req/gnt/rvalid handshake. It sits between the two client datapaths and the array, replacing direct asynchronous access with one clocked, serialized access per grant.

---
 rtl/rw_arb_pkg.sv | 28 ++
 rtl/rw_4x4_sync.sv | 39 +++
 rtl/rw_4x4_arbiter.sv | 137 +++++++++++++
 tb/tb_rw_4x4_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rw_arb_pkg.sv
// rw_arb_pkg: shared definitions for the two-port read/write arbiter.
//   - state_t     : arbiter FSM encoding (IDLE, ACCESS)
//   - DEF_DW/AW   : default data and address widths
//   - P0/P1       : port-index constants, also the encoding of the owner
//                   and last-grant registers
//   - pick_winner : round-robin selection between the two requesters
package rw_arb_pkg;

  localparam int DEF_DW = 4;
  localparam int DEF_AW = 2;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Lone requester wins; on a tie the port that was not granted last wins.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last_gnt);
    if (r0 && r1) return ~last_gnt;
    if (r0)       return P0;
    return P1;
  endfunction

endpackage

// File: rtl/rw_4x4_sync.sv
// rw_4x4_sync: single-port clocked storage array.
//   clk, rst_n : clock and asynchronous active-low reset (clears array and
//                read register)
//   en         : access strobe for this cycle
//   we         : 1 = write wdata to mem[addr], 0 = read mem[addr]
//   addr       : entry address
//   wdata      : write data
//   rdata      : registered read data, updated only by a read access
module rw_4x4_sync #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array sits in the reset branch because every entry must read
  // back as zero after rst_n; this forces flops rather than a RAM macro,
  // which is fine at this depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/rw_4x4_arbiter.sv
// rw_4x4_arbiter: round-robin arbiter/sequencer giving two requesters
// serialized access to one shared rw_4x4_sync array.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req0/req1         : access request per port
//   we0/we1           : 1 = write, 0 = read (qualified by req)
//   addr0/addr1       : entry address per port
//   wdata0/wdata1     : write data per port
//   gnt0/gnt1         : one-cycle registered grant pulse (the ACCESS cycle)
//   rvalid0/rvalid1   : one-cycle read-data-valid pulse, cycle after grant
//   rdata0/rdata1     : read data, held until that port's next read
module rw_4x4_arbiter
  import rw_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1
);

  state_t state, state_next;
  logic   owner, owner_next;
  logic   last_gnt, last_gnt_next;
  logic   gnt0_next, gnt1_next;
  logic   rvalid0_next, rvalid1_next;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] hold0, hold1;

  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    owner_next    = owner;
    last_gnt_next = last_gnt;
    gnt0_next     = 1'b0;
    gnt1_next     = 1'b0;
    rvalid0_next  = 1'b0;
    rvalid1_next  = 1'b0;
    mem_en        = 1'b0;
    mem_we        = (owner == P1) ? we1    : we0;
    mem_addr      = (owner == P1) ? addr1  : addr0;
    mem_wdata     = (owner == P1) ? wdata1 : wdata0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_next    = pick_winner(req0, req1, last_gnt);
          last_gnt_next = owner_next;
          gnt0_next     = (owner_next == P0);
          gnt1_next     = (owner_next == P1);
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        // The owner holds its inputs through the grant cycle, so they are
        // used live at the edge that closes ACCESS.
        mem_en       = 1'b1;
        rvalid0_next = !mem_we && (owner == P0);
        rvalid1_next = !mem_we && (owner == P1);
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= P0;
      last_gnt <= P1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      last_gnt <= last_gnt_next;
      gnt0     <= gnt0_next;
      gnt1     <= gnt1_next;
      rvalid0  <= rvalid0_next;
      rvalid1  <= rvalid1_next;
    end
  end

  // The array's read register is shared by both ports, so each port keeps
  // its own copy captured during its rvalid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (rvalid0) hold0 <= mem_rdata;
      if (rvalid1) hold1 <= mem_rdata;
    end
  end

  // Both mux legs and the select are flops, so outputs stay registered.
  assign rdata0 = rvalid0 ? mem_rdata : hold0;
  assign rdata1 = rvalid1 ? mem_rdata : hold1;

  rw_4x4_sync #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_rw_4x4_arbiter.sv
// Self-checking bench for rw_4x4_arbiter: directed accesses, with expected
// read data pushed into per-port queues and checked by a monitor on rvalid.
module tb_rw_4x4_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [1:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [3:0] rdata0, rdata1;

  int errors = 0;
  int checks = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  rw_4x4_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .req1   (req1),
    .we0    (we0),
    .we1    (we1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .rvalid0(rvalid0),
    .rvalid1(rvalid1),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Monitor: exclusivity of pulses and read data against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt0 || gnt1) check("gnt_exclusive", gnt0 & gnt1, 1'b0);
      if (rvalid0 || rvalid1) check("rvalid_exclusive", rvalid0 & rvalid1, 1'b0);
      if (rvalid0) begin
        if (q0.size() == 0) check("rvalid0_unexpected", rvalid0, 1'b0);
        else check("rdata0", rdata0, q0.pop_front());
      end
      if (rvalid1) begin
        if (q1.size() == 0) check("rvalid1_unexpected", rvalid1, 1'b0);
        else check("rdata1", rdata1, q1.pop_front());
      end
    end
  end

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [1:0] a, input logic [3:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Issue one access from port p and wait for its grant. Called at
  // posedge+1; returns at posedge+1 of the cycle after the grant, with req
  // dropped unless drop == 0 (back-to-back requests).
  task automatic do_access(input int p, input logic w, input logic [1:0] a,
                           input logic [3:0] d, input logic [3:0] exp_rd,
                           input int exp_lat, input bit drop);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 0;
    drive(p, 1'b1, w, a, d);
    while (!seen && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      seen = (p == 0) ? gnt0 : gnt1;
    end
    if (!seen) begin
      check("gnt_timeout", 32'd0, 32'd1);
    end else begin
      check($sformatf("gnt%0d_latency", p), lat, exp_lat);
      if (!w) begin
        if (p == 0) q0.push_back(exp_rd);
        else        q1.push_back(exp_rd);
      end
    end
    @(posedge clk); #1;
    check($sformatf("rvalid%0d_after_gnt", p), (p == 0) ? rvalid0 : rvalid1, !w);
    if (drop) drive(p, 1'b0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 4'd0);
    repeat (2) @(negedge clk);
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_rvalid0", rvalid0, 1'b0);
    check("rst_rvalid1", rvalid1, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int budget;
    bit got0, got1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 4'd0);

    // Reset state.
    apply_reset();
    check("rst_rdata0", rdata0, 4'h0);
    check("rst_rdata1", rdata1, 4'h0);

    // Single-port write then read.
    do_access(0, 1'b1, 2'd2, 4'hA, 4'h0, 1, 1);
    do_access(0, 1'b0, 2'd2, 4'h0, 4'hA, 1, 1);
    repeat (2) @(posedge clk); #1;
    check("rdata0_held", rdata0, 4'hA);

    // Simultaneous requests from reset: port 0 wins the first tie.
    apply_reset();
    fork
      do_access(0, 1'b1, 2'd1, 4'h5, 4'h0, 1, 1);
      do_access(1, 1'b0, 2'd1, 4'h0, 4'h5, 3, 1);
    join

    // Round-robin: preload, last grant ends on port 1, then both hold req.
    do_access(0, 1'b1, 2'd0, 4'h6, 4'h0, 1, 1);
    do_access(1, 1'b1, 2'd1, 4'h9, 4'h0, 1, 1);
    drive(0, 1'b1, 1'b0, 2'd0, 4'd0);
    drive(1, 1'b1, 1'b0, 2'd1, 4'd0);
    k = 0;
    budget = 0;
    while (k < 8 && budget < 40) begin
      @(posedge clk); #1;
      budget++;
      got0 = gnt0;
      got1 = gnt1;
      if (got0 || got1) begin
        check($sformatf("rr_grant_%0d", k), got1, k % 2);
        if (got0) q0.push_back(4'h6);
        if (got1) q1.push_back(4'h9);
        k++;
      end
    end
    if (k < 8) check("rr_timeout", k, 8);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 4'd0);
    @(posedge clk); #1;

    // Back-to-back reads on port 1 after preloading 1..4.
    for (int i = 0; i < 4; i++)
      do_access(0, 1'b1, 2'(i), 4'(i + 1), 4'h0, 1, 1);
    for (int i = 0; i < 4; i++)
      do_access(1, 1'b0, 2'(i), 4'h0, 4'(i + 1), 1, (i == 3));

    // Reset in the middle of port 1's write grant.
    drive(1, 1'b1, 1'b1, 2'd3, 4'hF);
    budget = 0;
    got1   = 0;
    while (!got1 && budget < 10) begin
      @(posedge clk); #1;
      budget++;
      got1 = gnt1;
    end
    check("abort_gnt1_seen", got1, 1'b1);
    apply_reset();
    for (int i = 0; i < 4; i++)
      do_access(0, 1'b0, 2'(i), 4'h0, 4'h0, 1, 1);

    repeat (4) @(posedge clk); #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
